// File: rtl/montgomery_encoder.sv
// Montgomery-domain encoder: result = x * 2^m_bl mod m, one shift/subtract per cycle.
// Optional contract-check output err_o is enabled with `define MONT_ENC_ERR_EN.

package multiplier_pkg;
  parameter int DATA_LENGTH = 64;
endpackage

module montgomery_encoder #(
  parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH,
  parameter int CNT_W       = $clog2(DATA_LENGTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   busy_o
`ifdef MONT_ENC_ERR_EN
  ,
  output logic                   err_o
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [DATA_LENGTH:0]   acc, acc_nxt, dbl;
  logic [DATA_LENGTH-1:0] m_q;
  logic [CNT_W-1:0]       cnt, cnt_nxt, bl_cnt;
  logic                   accept;

  assign bl_cnt = m_bl_i[CNT_W-1:0];
  assign accept = (state == IDLE) && start_i;
  assign busy_o = (state != IDLE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    // One extra bit keeps 2*acc exact before the conditional subtract.
    dbl       = acc << 1;
    case (state)
      IDLE: begin
        if (start_i) begin
          acc_nxt   = {1'b0, x_i};
          cnt_nxt   = bl_cnt;
          state_nxt = (bl_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_nxt = (dbl >= {1'b0, m_q}) ? dbl - {1'b0, m_q} : dbl;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      m_q      <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      valid_o <= (state == DONE);
      if (accept) m_q <= m_i;
      if (state == DONE) result_o <= acc[DATA_LENGTH-1:0];
    end
  end

`ifdef MONT_ENC_ERR_EN
  logic err_chk, err_q;

  // Evaluated on the values being latched, so it matches what the engine runs on.
  always_comb begin
    err_chk = 1'b0;
    if (x_i >= m_i)                                   err_chk = 1'b1;
    if (!m_i[0])                                      err_chk = 1'b1;
    if (m_i < DATA_LENGTH'(3))                        err_chk = 1'b1;
    if (m_bl_i > DATA_LENGTH'(DATA_LENGTH))           err_chk = 1'b1;
    if ((m_i >> m_bl_i) != '0)                        err_chk = 1'b1;
    if ((m_i >> (m_bl_i - DATA_LENGTH'(1))) == '0)    err_chk = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (accept) err_q <= err_chk;
      err_o <= (state == DONE) && err_q;
    end
  end
`else
  logic unused_bl_hi;
  assign unused_bl_hi = ^m_bl_i[DATA_LENGTH-1:CNT_W];
`endif

endmodule

// File: doc/montgomery_encoder.md
Name: montgomery_encoder

Overview:
- Converts a plain residue into the Montgomery domain: result = x·R mod m, with R = 2^m_bl.
- Opposite direction of the existing Montgomery reduction (decode) block. Pair it in front of the reduction path so that decode(encode(x)) = x.
- Sequential shift-and-conditional-subtract engine: one bit of R per cycle, no multiplier instance.
- Operand widths come from multiplier_pkg (DATA_LENGTH).

Parameters:
- DATA_LENGTH, 64 (from multiplier_pkg), operand/result width.
- CNT_W, $clog2(DATA_LENGTH+1), width of the iteration counter.

Ports:
- clk_i  input  1  clock, rising edge active.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  start pulse, sampled only in IDLE.
- x_i  input  DATA_LENGTH  value to encode. Contract: x_i < m_i.
- m_i  input  DATA_LENGTH  modulus. Contract: odd, ≥3, 2^(m_bl−1) ≤ m_i < 2^m_bl.
- m_bl_i  input  DATA_LENGTH  bit length of m. Legal range 0..DATA_LENGTH; only the low CNT_W bits are used.
- result_o  output  DATA_LENGTH  x·2^m_bl mod m. Holds until the next valid_o.
- valid_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- busy_o  output  1  high while an operation is in flight.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state=IDLE; result_o, acc, cnt, operand registers = 0.
  - valid_o=0, busy_o=0.
  - Reset mid-operation aborts the operation with no valid_o pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start_i=1: latch m_i and m_bl_i; acc ← {1'b0, x_i}; cnt ← m_bl_i.
  - Next state is SHIFT if m_bl_i ≠ 0, else DONE.
  - start_i=0: stay in IDLE.
- SHIFT, each edge:
  - t = acc<<1 (DATA_LENGTH+1 bits, no truncation).
  - acc ← (t ≥ m) ? t−m : t.
  - cnt ← cnt−1.
  - When cnt=1 before the edge, next state is DONE.
- DONE, one edge:
  - result_o ← acc[DATA_LENGTH-1:0].
  - valid_o ← 1 for exactly one cycle; next state IDLE.
- Latency: start accepted at edge T → valid_o high in the cycle after edge T+m_bl+1.
  - m_bl=0: valid_o after edge T+1, with result_o=x_i.
- busy_o is high in SHIFT and DONE, low in IDLE.
  - busy_o is already low in the valid_o cycle, so start_i may be accepted in that same cycle (back-to-back operation, no bubble).
- start_i while busy_o=1 is ignored: no queuing, latched operands unchanged.
- Input changes after acceptance have no effect (operands are latched).
- Arithmetic invariant: acc < m after every SHIFT step, given the input contract. The acc width of DATA_LENGTH+1 bits covers 2·(m−1) for m < 2^DATA_LENGTH.
- Contract violation (x ≥ m, even m, m outside the bit-length range):
  - Timing is identical: valid_o is still pulsed at the same latency.
  - result_o value is don't-care.
  - The FSM never locks up.
- m_bl_i > DATA_LENGTH: treated as a contract violation; same timing rules apply to the truncated count.

Optional Feature:
- Macro: MONT_ENC_ERR_EN.
- Defined:
  - Adds output port err_o (1 bit, reset 0).
  - Contract checks run at start acceptance, on the latched values: x ≥ m, m[0]=0, m<3, m_bl>DATA_LENGTH, m ≥ 2^m_bl, m < 2^(m_bl−1).
  - err_o is asserted together with valid_o when any check fails, and is low otherwise. It is a one-cycle pulse aligned with valid_o.
  - Timing and result_o are unchanged.
- Undefined: no err_o port and no check logic.

Test Plan:
- m=13, m_bl=4, x=5, start at edge T → valid_o after edge T+5, result_o=2 (80 mod 13). busy_o high for 5 cycles.
- m=97, m_bl=7, x=96 → result_o=66 (12288 mod 97), latency 8 edges. Also x=0 → result_o=0.
- DATA_LENGTH=64, m=0x1FFFFFFFFFFFFFFF, m_bl=61, x=1 → result_o=1 (2^61 mod m), latency 62 edges. Also x=m−1 → result_o=m−1.
- Round trip: encode x=5 (m=13, m_bl=4) → 2. Feed 2 into the Montgomery reduction block with the matching m, m_bl, minv → 5.
- Two starts:
  - Second start_i pulsed mid-operation with different x → ignored; first result is correct; one valid_o only.
  - start_i asserted in the valid_o cycle → accepted; second valid_o exactly m_bl+1 edges later.
- Reset and error path:
  - rst_ni low during SHIFT (m=97, m_bl=7) → valid_o/busy_o/result_o = 0 immediately, no valid_o pulse. Next start completes correctly.
  - With MONT_ENC_ERR_EN: x=20, m=13 → err_o=1 with valid_o. Legal case → err_o=0.
